// File: rtl/fetch_unit_pkg.sv
// fetch_types: shared FSM state and queue entry types for the fetch stage
package fetch_types;
   localparam int FETCH_XLEN = 32;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} fetch_state_t;
   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetch entries with flush; head read straight from storage
module fetch_queue
   import fetch_types::*;
#(
   parameter int DEPTH = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enq,
   input  entry_t                     enq_data,
   input  logic                       deq,
   input  logic                       flush,
   output entry_t                     head,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   entry_t mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic do_deq, do_enq;
   assign do_deq = deq && !flush && count != '0;
   assign do_enq = enq && !flush;
   assign head = mem[rp];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         wp <= do_enq ? wp + PW'(1) : wp;
         rp <= do_deq ? rp + PW'(1) : rp;
         count <= count + CW'(do_enq) - CW'(do_deq);
      end
   end
   always_ff @(posedge clk)
      if (do_enq) mem[wp] <= enq_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, icache read/resp handshake and prefetch queue with redirect flush
module fetch_unit
   import fetch_types::*;
#(
   parameter int XLEN = 32,
   parameter int QUEUE_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0060)
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic                             icache_read,
   output logic [XLEN-1:0]                  icache_addr,
   input  logic [XLEN-1:0]                  icache_rdata,
   input  logic                             icache_resp,
   input  logic                             redirect_valid,
   input  logic [XLEN-1:0]                  redirect_pc,
   input  logic                             deq_ready,
   output logic                             deq_valid,
   output logic [XLEN-1:0]                  deq_instr,
   output logic [XLEN-1:0]                  deq_pc,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy
);
   localparam int CW = $clog2(QUEUE_DEPTH+1);
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;
   fetch_state_t state, state_n;
   logic [XLEN-1:0] fetch_pc, fetch_pc_n, drop_addr, drop_addr_n, redir_pc;
   logic enq, deq_fire;
   entry_t head;
   assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
   assign deq_valid = occupancy != '0;
   assign deq_fire = deq_valid && deq_ready;
   assign deq_pc = head.pc;
   assign deq_instr = head.instr;
   assign icache_read = state != S_IDLE;
   assign icache_addr = state == S_DROP ? drop_addr : fetch_pc;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         fetch_pc <= RESET_PC;
         drop_addr <= RESET_PC;
      end else begin
         state <= state_n;
         fetch_pc <= fetch_pc_n;
         drop_addr <= drop_addr_n;
      end
   end
   // The slot of an issued request is already reserved, so staying in S_REQ
   // only needs a free slot beyond the one just filled.
   always_comb begin
      state_n = state;
      fetch_pc_n = fetch_pc;
      drop_addr_n = drop_addr;
      enq = 1'b0;
      case (state)
         S_IDLE: begin
            fetch_pc_n = redirect_valid ? redir_pc : fetch_pc;
            state_n = !redirect_valid && occupancy < CW'(QUEUE_DEPTH) ? S_REQ : S_IDLE;
         end
         S_REQ: begin
            if (redirect_valid) begin
               fetch_pc_n = redir_pc;
               drop_addr_n = fetch_pc;
               state_n = icache_resp ? S_REQ : S_DROP;
            end else if (icache_resp) begin
               enq = 1'b1;
               fetch_pc_n = fetch_pc + XLEN'(4);
               state_n = deq_fire || occupancy < CW'(QUEUE_DEPTH - 1) ? S_REQ : S_IDLE;
            end
         end
         S_DROP: begin
            fetch_pc_n = redirect_valid ? redir_pc : fetch_pc;
            state_n = icache_resp ? S_REQ : S_DROP;
         end
         default: state_n = S_IDLE;
      endcase
   end
   fetch_queue #(.DEPTH(QUEUE_DEPTH), .entry_t(entry_t)) u_queue (
      .clk(clk),
      .rst(rst),
      .enq(enq),
      .enq_data(entry_t'{pc: fetch_pc, instr: icache_rdata}),
      .deq(deq_ready),
      .flush(redirect_valid),
      .head(head),
      .count(occupancy)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch sequencing, credit stall, redirect and async reset
module tb_fetch_unit;
   localparam logic [31:0] K = 32'hA5A5_0000;
   logic clk = 1'b0, rst = 1'b1;
   logic icache_read, icache_resp = 1'b0, redirect_valid = 1'b0, deq_ready = 1'b0, deq_valid;
   logic [31:0] icache_addr, icache_rdata = '0, redirect_pc = '0, deq_instr, deq_pc;
   logic [2:0] occupancy;
   logic auto = 1'b0;
   int n_checks = 0, n_fail = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst),
      .icache_read(icache_read), .icache_addr(icache_addr),
      .icache_rdata(icache_rdata), .icache_resp(icache_resp),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .deq_ready(deq_ready), .deq_valid(deq_valid),
      .deq_instr(deq_instr), .deq_pc(deq_pc), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive_resp();
      if (auto) begin
         icache_resp = icache_read;
         icache_rdata = icache_addr ^ K;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive_resp();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      auto = 1'b0;
      icache_resp = 1'b0;
      redirect_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      tick();
      chk("rst_read", {31'b0, icache_read}, 32'h0);
      chk("rst_addr", icache_addr, 32'h60);
      chk("rst_deq_valid", {31'b0, deq_valid}, 32'h0);
      chk("rst_occ", {29'b0, occupancy}, 32'h0);

      // streaming with immediate consumption
      do_reset();
      deq_ready = 1'b1;
      auto = 1'b1;
      tick();
      chk("s1_addr0", icache_addr, 32'h60);
      chk("s1_read0", {31'b0, icache_read}, 32'h1);
      chk("s1_occ0", {29'b0, occupancy}, 32'h0);
      for (int k = 2; k < 7; k++) begin
         tick();
         chk("s1_addr", icache_addr, 32'h60 + 32'(4 * (k - 1)));
         chk("s1_deq_pc", deq_pc, 32'h60 + 32'(4 * (k - 2)));
         chk("s1_deq_instr", deq_instr, (32'h60 + 32'(4 * (k - 2))) ^ K);
         chk("s1_occ", {29'b0, occupancy}, 32'h1);
      end

      // credit stall with consumer blocked
      do_reset();
      deq_ready = 1'b0;
      auto = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      chk("s2_read_off", {31'b0, icache_read}, 32'h0);
      chk("s2_occ_full", {29'b0, occupancy}, 32'h4);
      chk("s2_head", deq_pc, 32'h60);
      tick();
      chk("s2_still_idle", {31'b0, icache_read}, 32'h0);
      deq_ready = 1'b1;
      tick();
      deq_ready = 1'b0;
      chk("s2_occ3", {29'b0, occupancy}, 32'h3);
      chk("s2_head2", deq_pc, 32'h64);
      tick();
      chk("s2_refetch_read", {31'b0, icache_read}, 32'h1);
      chk("s2_refetch_addr", icache_addr, 32'h70);
      tick();
      chk("s2_after_read", {31'b0, icache_read}, 32'h0);
      chk("s2_after_occ", {29'b0, occupancy}, 32'h4);
      tick();
      chk("s2_single", {31'b0, icache_read}, 32'h0);

      // redirect with delayed response
      do_reset();
      deq_ready = 1'b1;
      auto = 1'b1;
      tick();
      tick();
      chk("s3_addr64", icache_addr, 32'h64);
      auto = 1'b0;
      icache_resp = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      chk("s3_drop_addr", icache_addr, 32'h64);
      chk("s3_drop_read", {31'b0, icache_read}, 32'h1);
      chk("s3_flushed", {31'b0, deq_valid}, 32'h0);
      tick();
      tick();
      chk("s3_hold_addr", icache_addr, 32'h64);
      icache_resp = 1'b1;
      icache_rdata = 32'hDEAD_BEEF;
      tick();
      icache_resp = 1'b0;
      chk("s3_new_addr", icache_addr, 32'h200);
      chk("s3_discarded", {29'b0, occupancy}, 32'h0);
      auto = 1'b1;
      drive_resp();
      tick();
      chk("s3_deq_pc", deq_pc, 32'h200);
      chk("s3_deq_instr", deq_instr, 32'h200 ^ K);

      // redirect coinciding with response
      do_reset();
      deq_ready = 1'b0;
      auto = 1'b1;
      tick();
      tick();
      tick();
      chk("s4_occ2", {29'b0, occupancy}, 32'h2);
      chk("s4_addr68", icache_addr, 32'h68);
      redirect_valid = 1'b1;
      redirect_pc = 32'h400;
      tick();
      redirect_valid = 1'b0;
      chk("s4_empty", {31'b0, deq_valid}, 32'h0);
      chk("s4_occ0", {29'b0, occupancy}, 32'h0);
      chk("s4_addr", icache_addr, 32'h400);
      tick();
      chk("s4_deq_pc", deq_pc, 32'h400);
      chk("s4_occ1", {29'b0, occupancy}, 32'h1);

      // misaligned redirect target
      redirect_valid = 1'b1;
      redirect_pc = 32'h203;
      tick();
      redirect_valid = 1'b0;
      chk("s5_addr", icache_addr, 32'h200);
      tick();
      chk("s5_deq_pc", deq_pc, 32'h200);
      chk("s5_deq_instr", deq_instr, 32'h200 ^ K);

      // asynchronous reset mid-request
      chk("s6_pre_read", {31'b0, icache_read}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("s6_read", {31'b0, icache_read}, 32'h0);
      chk("s6_addr", icache_addr, 32'h60);
      chk("s6_deq_valid", {31'b0, deq_valid}, 32'h0);
      chk("s6_occ", {29'b0, occupancy}, 32'h0);
      auto = 1'b0;
      icache_resp = 1'b0;
      tick();
      rst = 1'b0;
      deq_ready = 1'b1;
      auto = 1'b1;
      tick();
      chk("s6_restart", icache_addr, 32'h60);
      tick();
      chk("s6_next", icache_addr, 32'h64);
      chk("s6_deq_pc", deq_pc, 32'h60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage with a prefetch queue. It decouples the icache from decode so fetch continues while ID stalls. It owns the fetch PC, runs the icache read/resp handshake, and buffers {pc, instr} pairs. It supports redirect (branch/jump) with queue flush and drop of the in-flight request. It sits between the icache port and the IF/ID pipeline register.

Parameters:
XLEN, 32, data/address width.
QUEUE_DEPTH, 4, number of queue entries (power of two, >= 2).
RESET_PC, 32'h0000_0060, fetch PC after reset.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
icache_read  out  1  read request; held until icache_resp
icache_addr  out  XLEN  fetch address; stable while icache_read=1
icache_rdata  in  XLEN  instruction word, valid with icache_resp
icache_resp  in  1  single-cycle completion pulse
redirect_valid  in  1  branch/jump taken, from EX/MEM
redirect_pc  in  XLEN  redirect target
deq_ready  in  1  ID accepts head entry this cycle
deq_valid  out  1  queue non-empty
deq_instr  out  XLEN  head instruction
deq_pc  out  XLEN  head PC
occupancy  out  $clog2(QUEUE_DEPTH+1)  valid entries in queue

Behaviour:
- Reset (async): fetch_pc=RESET_PC, state=S_IDLE, queue empty, icache_read=0, deq_valid=0, occupancy=0, icache_addr=RESET_PC. Reset mid-request abandons the request; the icache is reset by the same rst.
- Credit rule: issue only when occupancy + outstanding < QUEUE_DEPTH (outstanding is 0 or 1). An issued request always has a reserved slot, so enqueue never overflows.
- FSM states: S_IDLE, S_REQ, S_DROP.
  - S_IDLE: icache_read=0. If redirect_valid, load fetch_pc. Otherwise, if credit is available, go to S_REQ next cycle.
  - S_REQ: icache_read=1, icache_addr=fetch_pc.
    - On resp with no redirect: enqueue {fetch_pc, icache_rdata}; fetch_pc+=4; stay in S_REQ if credit remains after the enqueue, else go to S_IDLE.
    - On redirect with resp in the same cycle: discard the data; fetch_pc=redirect_pc; go to S_REQ.
    - On redirect with no resp: go to S_DROP; fetch_pc=redirect_pc.
  - S_DROP: icache_read=1, icache_addr=the old address latched in drop_addr. Wait for resp, discard it, then go to S_REQ on the new fetch_pc. A further redirect while in S_DROP overwrites fetch_pc and keeps the state in S_DROP.
- Back-to-back: on resp in S_REQ with credit, icache_read stays high and the address advances by 4 in the next cycle.
- Queue:
  - Registered circular FIFO. Head is presented combinationally from storage.
  - Latency is resp at cycle t -> deq_valid at t+1.
  - Dequeue when deq_valid & deq_ready.
  - Simultaneous enqueue and dequeue leaves occupancy unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- Redirect priority: redirect_valid flushes all queue entries in the same cycle (deq_valid=0 next cycle) and overrides both enqueue and dequeue that cycle.
- deq_ready while empty: no effect.
- Alignment: redirect_pc[1:0] is forced to 2'b00. fetch_pc wraps modulo 2^XLEN.
- No combinational path from icache_resp or deq_ready to icache_read. All outputs except deq_* come from registers.

Decomposition:
- Package fetch_types:
  - fetch_state_t enum {S_IDLE, S_REQ, S_DROP}
  - fetch_entry_t packed struct {pc, instr}
- Sub-module fetch_queue: parametrised FIFO of fetch_entry_t with enq, deq, flush, count. The fetch_unit top holds the FSM, fetch_pc, drop_addr and credit logic.

Test Plan:
- Reset release, icache responds the cycle after each read, deq_ready=1 -> icache_addr sequence 0x60, 0x64, 0x68…; deq_pc lags by one cycle and matches; occupancy stays <= 1.
- deq_ready=0, instant resp -> exactly 4 entries fetched (0x60–0x6C); icache_read drops; occupancy=4. Raise deq_ready for one cycle -> a single new fetch at 0x70.
- Redirect to 0x200 while S_REQ at 0x64 with resp delayed 3 cycles -> icache_addr held at 0x64 until resp; data discarded; next read at 0x200; no 0x64 entry ever dequeued.
- Redirect to 0x400 in the same cycle as resp for 0x68, queue holding 2 entries -> queue empty next cycle; 0x68 not enqueued; next read address 0x400.
- redirect_pc=0x203 -> fetch starts at 0x200; deq_pc=0x200.
- Assert rst while icache_read=1 mid-request -> outputs return to reset values immediately without waiting for a clock edge; fetch restarts at 0x60 after release.
